// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO frame packer.
// Holds the packer FSM state encoding, the byte width and the default
// start-of-frame marker used when no SOF override is supplied.
package fifo_pkg;

  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] DEFAULT_SOF = 8'hA5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    HDR  = 3'd2,
    LEN  = 3'd3,
    PAY  = 3'd4,
    CSUM = 3'd5
  } packer_state_t;

endpackage

// File: rtl/frame_buf.sv
// Payload capture buffer for the frame packer.
// DEPTH x W register array with one synchronous write port and one
// asynchronous (combinational) read port.
// Ports:
//   clk   - clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address (reads beyond DEPTH-1 return 0)
//   rdata - read data, combinational from raddr
module frame_buf
  import fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = DATA_W,
  parameter int AW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Storage is not reset: the packer's byte count decides what is valid.
  always_ff @(posedge clk) begin
    if (we && (waddr < AW'(DEPTH))) begin
      mem[waddr] <= wdata;
    end
  end

  // The packer pre-fetches idx+1, which can point one past the last entry.
  assign rdata = (raddr < AW'(DEPTH)) ? mem[raddr] : '0;

endmodule

// File: rtl/fifo_frame_packer.sv
// Drains a byte FIFO and emits framed packets on a valid/ready stream:
// SOF, LEN, LEN payload bytes, CSUM (CSUM makes LEN+payload+CSUM == 0 mod 256).
// A frame starts when the FIFO leaves almost-empty, or when it has been
// non-empty but almost-empty for TIMEOUT cycles.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   fifo_empty          - FIFO empty flag
//   fifo_almost_empty   - FIFO almost-empty flag
//   fifo_read_data      - FIFO data, valid the cycle after fifo_read_en
//   fifo_read_en        - FIFO read strobe (never while fifo_empty)
//   out_data/out_valid  - framed byte stream
//   out_ready           - sink ready
//   out_last            - marks the CSUM byte
//   busy                - FSM not in IDLE
//   state               - current FSM state (debug)
// Handshake: a byte transfers on a cycle where out_valid & out_ready are both
// high at posedge; while out_valid=1 and out_ready=0, out_data/out_valid/
// out_last hold their values, and out_valid never drops without a transfer.
module fifo_frame_packer
  import fifo_pkg::*;
#(
  parameter int                MAX_LEN = 16,
  parameter int                TIMEOUT = 64,
  parameter logic [DATA_W-1:0] SOF     = DEFAULT_SOF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic              fifo_almost_empty,
  input  logic [DATA_W-1:0] fifo_read_data,
  output logic              fifo_read_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output packer_state_t     state
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  packer_state_t     state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     issued_q, issued_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              pend_q;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              read_en;

  logic [CW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] cnt8;
  logic [DATA_W-1:0] csum;
  logic              xfer;

  frame_buf #(
    .DEPTH (MAX_LEN),
    .W     (DATA_W),
    .AW    (CW)
  ) u_buf (
    .clk   (clk),
    .we    (pend_q && (state_q == FILL)),
    .waddr (cnt_q),
    .wdata (fifo_read_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Output registers are loaded with the byte for the next state, so the
  // address must point at the byte following the one currently shown.
  assign rd_addr = (state_q == PAY) ? (idx_q + CW'(1)) : '0;
  assign cnt8    = DATA_W'(cnt_q);
  assign csum    = ~(cnt8 + sum_q) + DATA_W'(1);
  assign xfer    = valid_q && out_ready;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    cnt_d    = cnt_q;
    issued_d = issued_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    read_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && fifo_almost_empty) timer_d = timer_q + TW'(1);
        else                                  timer_d = '0;
        if (!fifo_empty && (!fifo_almost_empty || (timer_q == TW'(TIMEOUT - 1)))) begin
          state_d  = FILL;
          timer_d  = '0;
          cnt_d    = '0;
          issued_d = '0;
          sum_d    = '0;
        end
      end
      FILL: begin
        read_en = !fifo_empty && (issued_q < CW'(MAX_LEN));
        if (read_en) issued_d = issued_q + CW'(1);
        if (pend_q) begin
          cnt_d = cnt_q + CW'(1);
          sum_d = sum_q + fifo_read_data;
        end
        // Leave only once no read is outstanding and none is being issued.
        if (!pend_q && !read_en) begin
          state_d = HDR;
          data_d  = SOF;
          valid_d = 1'b1;
          last_d  = 1'b0;
        end
      end
      HDR: begin
        if (xfer) begin
          state_d = LEN;
          data_d  = cnt8;
        end
      end
      LEN: begin
        if (xfer) begin
          state_d = PAY;
          idx_d   = '0;
          data_d  = rd_data;
        end
      end
      PAY: begin
        if (xfer) begin
          if (idx_q == (cnt_q - CW'(1))) begin
            state_d = CSUM;
            data_d  = csum;
            last_d  = 1'b1;
          end else begin
            idx_d  = idx_q + CW'(1);
            data_d = rd_data;
          end
        end
      end
      CSUM: begin
        if (xfer) begin
          state_d = IDLE;
          data_d  = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
          cnt_d   = '0;
          sum_d   = '0;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        data_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      cnt_q    <= '0;
      issued_q <= '0;
      idx_q    <= '0;
      sum_q    <= '0;
      pend_q   <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      issued_q <= issued_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      pend_q   <= read_en;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
    end
  end

  assign fifo_read_en = read_en && !reset;
  assign out_data     = data_q;
  assign out_valid    = valid_q;
  assign out_last     = last_q;
  assign busy         = (state_q != IDLE);
  assign state        = state_q;

endmodule

// File: tb/tb_fifo_frame_packer.sv
// Bench for fifo_frame_packer: a 32-deep byte FIFO model feeds the DUT,
// expected frame bytes are queued per scenario and a monitor checks every
// accepted output byte against the queue.
module tb_fifo_frame_packer;
  import fifo_pkg::*;

  localparam int DEPTH    = 32;
  localparam int AE_LEVEL = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              fifo_empty;
  logic              fifo_almost_empty;
  logic [7:0]        fifo_read_data = 8'h00;
  logic              fifo_read_en;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_last;
  logic              busy;
  packer_state_t     state;

  int compared = 0;
  int failed   = 0;
  logic [8:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  fifo_frame_packer #(
    .MAX_LEN (16),
    .TIMEOUT (64),
    .SOF     (8'hA5)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_read_data    (fifo_read_data),
    .fifo_read_en      (fifo_read_en),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_last          (out_last),
    .busy              (busy),
    .state             (state)
  );

  // ---------------- FIFO model ----------------
  logic [7:0] mem [DEPTH];
  int   wp = 0;
  int   rp = 0;
  int   count = 0;
  logic wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;

  assign fifo_empty        = (count == 0);
  assign fifo_almost_empty = (count <= AE_LEVEL);

  always @(posedge clk) begin
    int c;
    c = count;
    if (wr_en && count < DEPTH) begin
      mem[wp] <= wr_data;
      wp <= (wp + 1) % DEPTH;
      c++;
    end
    if (fifo_read_en && count > 0) begin
      fifo_read_data <= mem[rp];
      rp <= (rp + 1) % DEPTH;
      c--;
    end
    count <= c;
  end

  // ---------------- driver tasks ----------------
  task automatic write_seq(input logic [7:0] start, input logic [7:0] step, input int n);
    logic [7:0] b;
    b = start;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      wr_en   = 1'b1;
      wr_data = b;
      b = b + step;
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic exp_frame(input logic [7:0] len, input logic [7:0] start,
                           input logic [7:0] step, input logic [7:0] csum);
    logic [7:0] b;
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, len});
    b = start;
    for (int i = 0; i < int'(len); i++) begin
      exp_q.push_back({1'b0, b});
      b = b + step;
    end
    exp_q.push_back({1'b1, csum});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (n >= budget) begin
      failed++;
      $display("FAIL %s: timed out with %0d bytes outstanding, busy=%0b", name, exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  task automatic wait_accept(input logic [7:0] b, input int budget);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready && out_data == b) break;
      n++;
      if (n >= budget) begin
        compared++;
        failed++;
        $display("FAIL wait_byte_%0h: not seen within %0d cycles", b, budget);
        break;
      end
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [8:0] e;
    if (!reset && out_valid && out_ready) begin
      compared++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_byte: got last=%0b data=%0h with nothing expected", out_last, out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_last, out_data} !== e) begin
          failed++;
          $display("FAIL stream_byte: got last=%0b data=%0h expected last=%0b data=%0h",
                   out_last, out_data, e[8], e[7:0]);
        end
      end
    end
    if (fifo_read_en && fifo_empty) begin
      compared++;
      failed++;
      $display("FAIL read_when_empty: fifo_read_en=1 while fifo_empty=1 at %0t", $time);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data", {24'd0, out_data}, 32'd0);
    check("reset_out_last", {31'd0, out_last}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_read_en", {31'd0, fifo_read_en}, 32'd0);

    // 1: five bytes cross almost-empty
    exp_frame(8'h05, 8'h01, 8'h01, 8'hEC);
    write_seq(8'h01, 8'h01, 5);
    wait_idle("frame_5", 200);

    // 2: three bytes, forced out by the idle timeout
    exp_frame(8'h03, 8'h10, 8'h10, 8'h9D);
    write_seq(8'h10, 8'h10, 3);
    n = 0;
    while (!busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_not_early", {31'd0, (n >= 55)}, 32'd1);
    check("timeout_not_late", {31'd0, (n <= 68)}, 32'd1);
    wait_idle("frame_timeout", 200);

    // 3: twenty bytes -> full frame plus a timed-out short frame
    exp_frame(8'h10, 8'h01, 8'h01, 8'h68);
    exp_frame(8'h04, 8'h11, 8'h01, 8'hB2);
    write_seq(8'h01, 8'h01, 20);
    wait_idle("frame_split", 400);

    // 4: back-pressure during payload
    exp_frame(8'h05, 8'h01, 8'h01, 8'hEC);
    write_seq(8'h01, 8'h01, 5);
    wait_accept(8'h02, 200);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_data", {24'd0, out_data}, 32'h03);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_last", {31'd0, out_last}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle("frame_stall", 200);

    // 5: reset mid-payload aborts the frame
    exp_frame(8'h05, 8'h01, 8'h01, 8'hEC);
    write_seq(8'h01, 8'h01, 5);
    wait_accept(8'h02, 200);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_out_data", {24'd0, out_data}, 32'd0);
    check("abort_out_last", {31'd0, out_last}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_read_en", {31'd0, fifo_read_en}, 32'd0);
    exp_frame(8'h05, 8'h0A, 8'h01, 8'hBF);
    write_seq(8'h0A, 8'h01, 5);
    wait_idle("frame_after_abort", 200);

    // 6: empty FIFO stays quiet
    repeat (200) begin
      @(negedge clk);
      check("quiet_read_en", {31'd0, fifo_read_en}, 32'd0);
      check("quiet_out_valid", {31'd0, out_valid}, 32'd0);
      check("quiet_busy", {31'd0, busy}, 32'd0);
    end

    check("leftover_expected", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
